spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the on-chip single-port RAM.
- Deserialises MOSI frames into 10-bit words (2-bit opcode + 8-bit payload) and presents each with a one-cycle rx_valid strobe.
- For read transactions, captures the RAM's returned byte and serialises it onto MISO, MSB first.
- The SPI clock is the block clock; all sampling is on posedge clk.

Parameters:
- FRAME_BITS, 10, MOSI payload width per frame (opcode + data).
- TX_BITS, 8, width of the read-back byte shifted onto MISO.

Ports:
- clk  input  1  SPI/system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data in, MSB first.
- tx_data  input  8  read byte returned by the RAM.
- tx_valid  input  1  tx_data valid qualifier from the RAM.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  10  assembled frame: [9:8] opcode, [7:0] address/data.
- rx_valid  output  1  one-cycle strobe, rx_data complete.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD next cycle; else stay.
- CHK_CMD samples the command bit on MOSI:
  - 0 -> WRITE.
  - 1 and rd_addr_seen=0 -> READ_ADD.
  - 1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA shift FRAME_BITS MOSI bits MSB first into rx_data, one per cycle, counter 0..9.
- On the cycle after the 10th bit is captured: rx_valid=1 for exactly one cycle, rx_data stable from then until the next frame starts shifting.
- READ_ADD completion sets rd_addr_seen=1. READ_DATA completion clears it. WRITE leaves it unchanged.
- READ_DATA after rx_valid:
  - Waits (any number of cycles) for tx_valid=1 and latches tx_data.
  - Drives MISO with bit 7 on the next cycle, then bits 6..0 on the following 7 cycles.
  - MISO returns to 0 after bit 0.
  - tx_valid is ignored in all other states and phases.
- End of transaction: after frame completion (and after the MISO shift in READ_DATA), the block waits in its state until SS_n=1, then goes to IDLE.
- Abort: SS_n=1 in any non-IDLE state -> IDLE next cycle; no rx_valid; rd_addr_seen unchanged; MISO=0; counter cleared.
- Back-to-back frames: SS_n=1 for a single cycle is sufficient to return to IDLE and start a new frame.
- Async reset mid-frame: everything returns to reset values immediately; a partial frame never produces rx_valid.
- rx_data is not cleared between frames; only reset clears it.

Optional Feature:
- Macro SPI_FRAME_ERR_EN.
- When defined: adds output frame_err (1 bit, reset 0). It pulses high for one cycle in two cases:
  - SS_n rises mid-frame (counter 1..9, or during the MISO shift).
  - A completed frame's opcode is inconsistent with its state: WRITE with rx_data[9]=1, or READ_* with rx_data[9]=0. rx_valid still fires in this case.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_BITS/TX_BITS defaults.
- One natural sub-module: spi_shift_cnt, the bit counter with a load/done flag, reused for the 10-bit MOSI and 8-bit MISO phases.

Test Plan:
- Write address:
  - Stimulus: SS_n low, MOSI=0 then 00_0001_0101, SS_n high.
  - Required: rx_data=10'h015, rx_valid high exactly 1 cycle; rd_addr_seen stays 0.
- Write data:
  - Stimulus: command 0 + 01_1010_1010.
  - Required: rx_data=10'h1AA, rx_valid pulse.
- Read sequence:
  - Stimulus: command 1 + 10_0001_0101, then command 1 + 11_0000_0000; tx_data=8'hC3 with tx_valid 2 cycles after rx_valid.
  - Required: second frame enters READ_DATA; MISO emits 1,1,0,0,0,0,1,1; rd_addr_seen back to 0.
- Abort:
  - Stimulus: SS_n raised after 5 payload bits.
  - Required: IDLE next cycle, no rx_valid, rd_addr_seen unchanged; with SPI_FRAME_ERR_EN, frame_err pulses once.
- Async reset:
  - Stimulus: rst_n pulsed low during the MISO shift.
  - Required: MISO=0, rx_valid=0, rx_data=0 immediately; a following write frame completes normally.
- Back-to-back:
  - Stimulus: two write frames separated by one SS_n-high cycle.
  - Required: two rx_valid pulses with correct rx_data each.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states, opcodes and size defaults for the SPI slave front end
package spi_pkg;

  localparam int DEF_FRAME_BITS = 10;
  localparam int DEF_TX_BITS    = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  // Sub-phase inside WRITE / READ_ADD / READ_DATA.
  typedef enum logic [1:0] {PH_SHIFT, PH_WAIT_TX, PH_TX, PH_HOLD} phase_t;

  function automatic logic op_is_read(input logic [1:0] op);
    case (op)
      OP_WR_ADDR, OP_WR_DATA: return 1'b0;
      OP_RD_ADDR, OP_RD_DATA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_cnt.sv
// rtl/spi_shift_cnt.sv - wrapping bit counter with load and done flag, shared by MOSI and MISO phases
module spi_shift_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         done
);

  assign done = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end: MOSI frame deserialiser and MISO read-back serialiser
// Optional macro SPI_FRAME_ERR_EN adds the frame_err pulse output.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int TX_BITS    = DEF_TX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic [TX_BITS-1:0]    tx_data,
  input  logic                  tx_valid,
  output logic                  MISO,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CNT_W = $clog2((FRAME_BITS > TX_BITS) ? FRAME_BITS : TX_BITS);

  state_t                state;
  phase_t                phase;
  logic                  rd_addr_seen;
  logic [TX_BITS-1:0]    tx_byte;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_last;
  logic                  cnt_done;
  logic                  cnt_en;
  logic                  in_frame;
  logic                  abort;
  logic                  tx_next_bit;
  logic [FRAME_BITS-1:0] rx_next;

  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign abort    = (state != IDLE) && SS_n;
  assign cnt_en   = in_frame && ((phase == PH_SHIFT) || (phase == PH_TX));
  assign cnt_last = (phase == PH_TX) ? CNT_W'(TX_BITS - 1) : CNT_W'(FRAME_BITS - 1);
  assign rx_next  = {rx_data[FRAME_BITS-2:0], MOSI};

  // While bit (TX_BITS-1-cnt) is on MISO, pick the one that follows it.
  always_comb begin
    tx_next_bit = 1'b0;
    for (int i = 0; i < TX_BITS - 1; i++) begin
      if (cnt == CNT_W'(TX_BITS - 2 - i)) tx_next_bit = tx_byte[i];
    end
  end

  spi_shift_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (abort),
    .en   (cnt_en),
    .last (cnt_last),
    .cnt  (cnt),
    .done (cnt_done)
  );

`ifdef SPI_FRAME_ERR_EN
  logic mid_frame;
  logic op_bad;
  assign mid_frame = in_frame && (((phase == PH_SHIFT) && (cnt != '0)) || (phase == PH_TX));
  assign op_bad    = ((state == WRITE) == op_is_read(rx_next[FRAME_BITS-1 -: 2]));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= PH_SHIFT;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_byte      <= '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (abort) begin
        state <= IDLE;
        phase <= PH_SHIFT;
        MISO  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err <= mid_frame;
`endif
      end else begin
        case (state)
          IDLE: if (!SS_n) state <= CHK_CMD;
          CHK_CMD: begin
            phase <= PH_SHIFT;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            case (phase)
              PH_SHIFT: begin
                rx_data <= rx_next;
                if (cnt_done) begin
                  rx_valid <= 1'b1;
                  phase    <= (state == READ_DATA) ? PH_WAIT_TX : PH_HOLD;
                  if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                  if (state == READ_DATA) rd_addr_seen <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                  frame_err <= op_bad;
`endif
                end
              end
              PH_WAIT_TX: begin
                if (tx_valid) begin
                  tx_byte <= tx_data;
                  MISO    <= tx_data[TX_BITS-1];
                  phase   <= PH_TX;
                end
              end
              PH_TX: begin
                MISO <= cnt_done ? 1'b0 : tx_next_bit;
                if (cnt_done) phase <= PH_HOLD;
              end
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - randomized self-checking bench for spi_slave_if against a transaction-level model
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad = 0;
  int n_rxv = 0;
  int n_err = 0;

  logic       rd_seen = 1'b0;
  logic [9:0] exp_rx = 10'h000;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) n_rxv++;
`ifdef SPI_FRAME_ERR_EN
    if (frame_err === 1'b1) n_err++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  task automatic drive(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    SS_n = ss;
    MOSI = mosi;
    tx_valid = txv;
    tx_data = txd;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One SS_n-framed transaction. abort_at<10 raises SS_n after that many payload bits;
  // miso_stop>0 ends a read-back after that many MISO bits, by SS_n or (miso_rst) by reset.
  task automatic frame(input logic cmd, input logic [9:0] word, input int abort_at,
                       input logic [7:0] txb, input int tx_delay, input int miso_stop,
                       input logic miso_rst, input int gap);
    int rxv0, err0, e_err, e_rxv;
    logic rd_data, ss_up;
    logic [9:0] w;
    logic [7:0] sh;
    rxv0 = n_rxv;
    err0 = n_err;
    e_err = 0;
    e_rxv = 0;
    ss_up = 1'b0;
    rd_data = cmd & rd_seen;
    w = word;
    drive(1'b0, rnd1(), rnd1(), rnd8());
    step();
    drive(1'b0, cmd, rnd1(), rnd8());
    step();
    for (int i = 0; i < abort_at && i < 10; i++) begin
      drive(1'b0, w[9], rnd1(), rnd8());
      w = w << 1;
      step();
    end
    if (abort_at < 10) begin
      drive(1'b1, rnd1(), rnd1(), rnd8());
      step();
      ss_up = 1'b1;
      check("abort_miso", MISO, 1'b0);
      if (abort_at > 0) e_err++;
      exp_rx = (exp_rx << abort_at) | (word >> (10 - abort_at));
    end else begin
      e_rxv = 1;
      check("rx_valid", rx_valid, 1'b1);
      check("rx_data", rx_data, word);
      exp_rx = word;
      if (cmd ? !word[9] : word[9]) e_err++;
      if (cmd) rd_seen = !rd_data;
      if (rd_data) begin
        for (int d = 0; d < tx_delay; d++) begin
          drive(1'b0, rnd1(), 1'b0, rnd8());
          step();
          check("miso_wait", MISO, 1'b0);
        end
        drive(1'b0, rnd1(), 1'b1, txb);
        step();
        sh = txb;
        for (int k = 0; k < 8; k++) begin
          check("miso_bit", MISO, sh[7]);
          sh = sh << 1;
          if (k + 1 == miso_stop) break;
          drive(1'b0, rnd1(), rnd1(), rnd8());
          step();
        end
        if (miso_stop > 0 && miso_rst) begin
          rst_n = 1'b0;
          #1;
          check("rst_miso", MISO, 1'b0);
          check("rst_rx_valid", rx_valid, 1'b0);
          check("rst_rx_data", rx_data, 10'h000);
          #1 rst_n = 1'b1;
          rd_seen = 1'b0;
          exp_rx = 10'h000;
          drive(1'b1, rnd1(), rnd1(), rnd8());
          step();
          ss_up = 1'b1;
        end else if (miso_stop > 0) begin
          drive(1'b1, rnd1(), rnd1(), rnd8());
          step();
          ss_up = 1'b1;
          check("miso_abort", MISO, 1'b0);
          e_err++;
        end else begin
          check("miso_end", MISO, 1'b0);
        end
      end
    end
    if (!ss_up) begin
      drive(1'b0, rnd1(), 1'b1, rnd8());
      step();
      check("miso_hold", MISO, 1'b0);
      drive(1'b0, rnd1(), 1'b0, rnd8());
      step();
      check("miso_hold", MISO, 1'b0);
      drive(1'b1, rnd1(), rnd1(), rnd8());
      step();
    end
    for (int g = 1; g < gap; g++) begin
      drive(1'b1, rnd1(), rnd1(), rnd8());
      step();
    end
    check("rx_valid_count", n_rxv - rxv0, e_rxv);
    check("rx_data_kept", rx_data, exp_rx);
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_count", n_err - err0, e_err);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_rx_data", rx_data, 10'h000);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_miso", MISO, 1'b0);
`ifdef SPI_FRAME_ERR_EN
    check("reset_frame_err", frame_err, 1'b0);
`endif
    rst_n = 1'b1;
    step();

    frame(1'b0, 10'h015, 10, 8'h00, 0, 0, 1'b0, 2);
    frame(1'b0, 10'h1AA, 10, 8'h00, 0, 0, 1'b0, 2);
    frame(1'b1, 10'h215, 10, 8'h00, 0, 0, 1'b0, 2);
    frame(1'b1, 10'h300, 10, 8'hC3, 2, 0, 1'b0, 2);
    frame(1'b1, 10'h2AB, 10, 8'h00, 0, 0, 1'b0, 1);
    frame(1'b1, 10'h3E7, 5, 8'h00, 0, 0, 1'b0, 1);
    frame(1'b1, 10'h3F0, 10, 8'h5A, 0, 0, 1'b0, 2);
    frame(1'b1, 10'h2AA, 10, 8'h00, 0, 0, 1'b0, 1);
    frame(1'b1, 10'h3C3, 10, 8'hA5, 1, 3, 1'b1, 1);
    frame(1'b0, 10'h0F0, 10, 8'h00, 0, 0, 1'b0, 1);
    frame(1'b0, 10'h13C, 10, 8'h00, 0, 0, 1'b0, 1);
    frame(1'b0, 10'h0C5, 10, 8'h00, 0, 0, 1'b0, 1);

    for (int n = 0; n < 80; n++) begin
      int ab, ms;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 10;
      ms = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      frame(rnd1(), 10'($urandom), ab, rnd8(), $urandom_range(0, 3), ms,
            ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
